// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load opcode
// bit positions and the load-response tracking states.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 175;
    localparam int MS_TO_WS_BUS_WD = 166;
    localparam int MS_TO_ES_BUS_WD = 38;

    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int LL_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } ms_state_t;

    typedef struct packed {
        logic [63:0] csr_bus;
        logic [5:0]  load_op;
        logic [2:0]  store_op;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] es_result;
        logic [31:0] pc;
        logic [31:0] inst;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side and data-SRAM-side signals of the memory stage, bundled so
// the stage and its environment share one connection point.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       flush;
    logic [5:0]                 stall;
    logic                       stallreq_ms;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;

    modport slave (
        input  flush, stall, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        output stallreq_ms, ms_to_ws_bus, ms_to_es_bus
    );

    modport master (
        output flush, stall, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        input  stallreq_ms, ms_to_ws_bus, ms_to_es_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of a load response and applies the
// sign or zero extension the load opcode asks for.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = rdata[{addr, 3'b000} +: 8];
    assign half_val = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        value = 32'h0;
        if (load_op[LD_B]) begin
            value = {{24{byte_val[7]}}, byte_val};
        end else if (load_op[LD_BU]) begin
            value = {24'h0, byte_val};
        end else if (load_op[LD_H]) begin
            value = {{16{half_val[15]}}, half_val};
        end else if (load_op[LD_HU]) begin
            value = {16'h0, half_val};
        end else if (load_op[LD_W] || load_op[LL_W]) begin
            value = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX bundle, waits for the load
// response, aligns it and hands the result to WB and back to EX.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    es_to_ms_t   ms_reg;
    ms_state_t   state;
    logic [31:0] hold_data;

    logic        load_pending;
    logic        data_ok;
    logic        mem_stall;
    logic        load_ready;
    logic        result_valid;
    logic [31:0] align_src;
    logic [31:0] aligned;
    logic [31:0] ms_result;
    logic        unused_ok;

    assign load_pending = |ms_reg.load_op;
    assign data_ok      = bus.data_sram_data_ok;
    assign mem_stall    = bus.stall[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_reg <= '0;
        end else if (bus.flush) begin
            ms_reg <= '0;
        end else if (bus.stall[3] && !bus.stall[4]) begin
            ms_reg <= '0;
        end else if (!bus.stall[3]) begin
            ms_reg <= es_to_ms_t'(bus.es_to_ms_bus);
        end
    end

    // A response that arrives while WB is stalled is parked in hold_data; a
    // flushed load whose response is still in flight is swallowed by S_DROP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            hold_data <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_pending) begin
                        if (!data_ok) begin
                            state <= bus.flush ? S_DROP : S_WAIT;
                        end else if (mem_stall && !bus.flush) begin
                            state     <= S_HOLD;
                            hold_data <= bus.data_sram_rdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        state <= data_ok ? S_IDLE : S_DROP;
                    end else if (data_ok) begin
                        if (mem_stall) begin
                            state     <= S_HOLD;
                            hold_data <= bus.data_sram_rdata;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.flush || !mem_stall) begin
                        state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign load_ready   = ((state == S_IDLE || state == S_WAIT) && data_ok) || (state == S_HOLD);
    assign result_valid = (state != S_DROP) && (!load_pending || load_ready);

    // S_DROP keeps EX stalled even on the stale response cycle so a younger
    // load never sees the dropped load's data.
    assign bus.stallreq_ms = (state == S_DROP) ||
                             (load_pending && (state == S_IDLE || state == S_WAIT) && !data_ok);

    assign align_src = (state == S_HOLD) ? hold_data : bus.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .load_op (ms_reg.load_op),
        .addr    (ms_reg.es_result[1:0]),
        .rdata   (align_src),
        .value   (aligned)
    );

    always_comb begin
        ms_result = ms_reg.es_result;
        if (load_pending) begin
            ms_result = result_valid ? aligned : 32'h0;
        end
    end

    assign bus.ms_to_ws_bus = {ms_reg.csr_bus, ms_reg.reg_we & result_valid, ms_reg.dest,
                               ms_result, ms_reg.pc, ms_reg.inst};
    assign bus.ms_to_es_bus = {ms_reg.reg_we & result_valid, ms_reg.dest, ms_result};

    assign unused_ok = ^{bus.stall[5], bus.stall[2:0], ms_reg.store_op};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/flush/stall/reset scenarios
// followed by a randomized instruction stream checked against a WB beat queue.
module tb_mem_stage;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] value;
        logic [31:0] pc;
    } exp_t;

    localparam int NUM_RAND   = 300;
    localparam int MAX_CYCLES = 20000;

    logic clk;
    logic rst_n;
    logic wb_stall;
    logic ex_stall;
    int   checks;
    int   failures;

    mem_stage_if bus();

    mem_stage dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Stall controller: WB stall backs up MEM and EX; a MEM request backs up EX.
    assign bus.stall = {wb_stall, wb_stall | bus.stallreq_ms,
                        {4{wb_stall | bus.stallreq_ms | ex_stall}}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [174:0] inst, input logic dok, input logic [31:0] rd,
                                 input logic wbs, input logic exs, input logic fl);
        @(negedge clk);
        bus.es_to_ms_bus      = inst;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata   = rd;
        bus.flush             = fl;
        wb_stall              = wbs;
        ex_stall              = exs;
        #1;
    endtask

    function automatic logic [174:0] mk_inst(input logic [5:0] lop, input logic [2:0] sop, input logic we,
                                             input logic [4:0] dest, input logic [31:0] res,
                                             input logic [31:0] pc);
        return {pc, ~pc, lop, sop, we, dest, res, pc, pc ^ 32'h5A5A_0F0F};
    endfunction

    // Reference load result: op 0..5 = ld.b, ld.h, ld.w, ld.bu, ld.hu, ll.w
    function automatic logic [31:0] ref_load(input int op, input logic [1:0] addr, input logic [31:0] word);
        int v;
        v = 0;
        case (op)
            0, 3: begin
                v = int'((word >> (8 * addr)) & 32'hFF);
                if (op == 0 && v >= 128) v = v - 256;
            end
            1, 4: begin
                v = int'((word >> (16 * (addr / 2))) & 32'hFFFF);
                if (op == 1 && v >= 32768) v = v - 65536;
            end
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    exp_t          exp_q[$];
    exp_t          e;
    logic [174:0]  cur_inst;
    logic          cur_valid;
    logic          cur_is_load;
    logic          cur_we;
    logic [4:0]    cur_dest;
    logic [31:0]   cur_value;
    logic [31:0]   cur_pc;
    logic [31:0]   cur_word;
    int            cur_lat;
    logic          resp_active;
    int            resp_lat;
    logic [31:0]   resp_word;
    logic          present;
    logic [31:0]   pc_ctr;
    int            issued;
    int            cycles;
    int            beats;

    task automatic gen_inst();
        int          kind;
        int          op;
        logic [31:0] addr;
        kind     = $urandom_range(0, 9);
        pc_ctr   = pc_ctr + 32'd4;
        cur_pc   = pc_ctr;
        cur_dest = 5'($urandom_range(0, 31));
        cur_is_load = 1'b0;
        if (kind < 5) begin
            op   = $urandom_range(0, 5);
            addr = $urandom;
            if (op == 1 || op == 4) addr[0] = 1'b0;
            cur_word    = $urandom;
            cur_lat     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
            cur_is_load = 1'b1;
            cur_we      = 1'b1;
            cur_value   = ref_load(op, addr[1:0], cur_word);
            cur_inst    = mk_inst(6'(1 << op), 3'b000, 1'b1, cur_dest, addr, cur_pc);
        end else if (kind < 9) begin
            cur_we    = ($urandom_range(0, 4) != 0);
            cur_value = $urandom;
            cur_inst  = mk_inst(6'b0, 3'b000, cur_we, cur_dest, cur_value, cur_pc);
        end else begin
            cur_we    = 1'b0;
            cur_value = $urandom;
            cur_inst  = mk_inst(6'b0, 3'($urandom_range(1, 4)), 1'b0, cur_dest, cur_value, cur_pc);
        end
        cur_valid = 1'b1;
    endtask

    initial begin
        logic [174:0] ld_a;
        logic [174:0] ld_b;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        ex_stall = 1'b0;
        bus.flush             = 1'b0;
        bus.es_to_ms_bus      = '0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;

        #3;
        checkOutput("reset_stallreq", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("reset_ws_bus", 64'(|bus.ms_to_ws_bus), 64'(0));
        checkOutput("reset_es_bus", 64'(|bus.ms_to_es_bus), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ld.b with immediate response");
        ld_a = mk_inst(6'b000001, 3'b000, 1'b1, 5'd3, 32'h1000_0003, 32'h100);
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("ldb_stallreq_a", 64'(bus.stallreq_ms), 64'(0));
        applyStimulus('0, 1'b1, 32'h80FF_1234, 1'b0, 1'b0, 1'b0);
        checkOutput("ldb_stallreq_b", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("ldb_result", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'hFFFF_FF80));
        checkOutput("ldb_we", 64'(bus.ms_to_ws_bus[101]), 64'(1));
        checkOutput("ldb_fwd", 64'(bus.ms_to_es_bus), 64'({1'b1, 5'd3, 32'hFFFF_FF80}));
        checkOutput("ldb_pc", 64'(bus.ms_to_ws_bus[63:32]), 64'(32'h100));
        checkOutput("ldb_csr", bus.ms_to_ws_bus[165:102], {32'h100, ~32'h100});
        checkOutput("ldb_inst", 64'(bus.ms_to_ws_bus[31:0]), 64'(32'h100 ^ 32'h5A5A_0F0F));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("ldb_after", 64'(|bus.ms_to_ws_bus), 64'(0));

        $display("[TB] ld.hu with late response");
        ld_a  = mk_inst(6'b010000, 3'b000, 1'b1, 5'd7, 32'h2000_0002, 32'h200);
        beats = 0;
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("ldhu_stallreq_%0d", i), 64'(bus.stallreq_ms), 64'(1));
            beats += int'(bus.ms_to_ws_bus[101]);
        end
        applyStimulus('0, 1'b1, 32'h8001_0000, 1'b0, 1'b0, 1'b0);
        checkOutput("ldhu_stallreq_done", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("ldhu_result", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'h0000_8001));
        beats += int'(bus.ms_to_ws_bus[101]);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        beats += int'(bus.ms_to_ws_bus[101]);
        checkOutput("ldhu_beats", 64'(beats), 64'(1));

        $display("[TB] ld.w response during WB stall");
        ld_a = mk_inst(6'b000100, 3'b000, 1'b1, 5'd9, 32'h3000_0000, 32'h300);
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_stallreq_b", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("hold_result_b", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'hDEAD_BEEF));
        applyStimulus('0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_stallreq_c", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("hold_result_c", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'hDEAD_BEEF));
        applyStimulus('0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_result_d", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'hDEAD_BEEF));
        checkOutput("hold_we_d", 64'(bus.ms_to_ws_bus[101]), 64'(1));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_after", 64'(|bus.ms_to_ws_bus), 64'(0));

        $display("[TB] flush while waiting, stale response dropped");
        ld_a = mk_inst(6'b000100, 3'b000, 1'b1, 5'd10, 32'h4000_0000, 32'h400);
        ld_b = mk_inst(6'b000100, 3'b000, 1'b1, 5'd11, 32'h4000_0004, 32'h404);
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_stallreq_b", 64'(bus.stallreq_ms), 64'(1));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("drop_stallreq_c", 64'(bus.stallreq_ms), 64'(1));
        applyStimulus(ld_b, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_stallreq_d", 64'(bus.stallreq_ms), 64'(1));
        checkOutput("drop_we_d", 64'(bus.ms_to_ws_bus[101]), 64'(0));
        applyStimulus(ld_b, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_stallreq_e", 64'(bus.stallreq_ms), 64'(1));
        checkOutput("drop_fwd_e", 64'(bus.ms_to_es_bus), 64'(0));
        checkOutput("drop_we_e", 64'(bus.ms_to_ws_bus[101]), 64'(0));
        applyStimulus(ld_b, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_stallreq_f", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("drop_fwd_f", 64'(bus.ms_to_es_bus), 64'(0));
        applyStimulus('0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_new_result", 64'(bus.ms_to_ws_bus[95:64]), 64'(32'h2222_2222));
        checkOutput("drop_new_we", 64'(bus.ms_to_ws_bus[101]), 64'(1));
        checkOutput("drop_new_pc", 64'(bus.ms_to_ws_bus[63:32]), 64'(32'h404));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_after", 64'(|bus.ms_to_ws_bus), 64'(0));

        $display("[TB] forward of add then bubble");
        ld_a = mk_inst(6'b0, 3'b000, 1'b1, 5'd5, 32'h42, 32'h500);
        ld_b = mk_inst(6'b0, 3'b000, 1'b1, 5'd6, 32'h77, 32'h504);
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(ld_b, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("fwd_add", 64'(bus.ms_to_es_bus), 64'({1'b1, 5'd5, 32'h42}));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_bubble_es", 64'(bus.ms_to_es_bus), 64'(0));
        checkOutput("fwd_bubble_ws", 64'(|bus.ms_to_ws_bus), 64'(0));

        $display("[TB] async reset while waiting");
        ld_a = mk_inst(6'b000100, 3'b000, 1'b1, 5'd12, 32'h6000_0000, 32'h600);
        applyStimulus(ld_a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_wait_stallreq", 64'(bus.stallreq_ms), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_stallreq", 64'(bus.stallreq_ms), 64'(0));
        checkOutput("rst_async_ws", 64'(|bus.ms_to_ws_bus), 64'(0));
        checkOutput("rst_async_es", 64'(|bus.ms_to_es_bus), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk_inst(6'b0, 3'b000, 1'b1, 5'd13, 32'h99, 32'h610), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_idle_stallreq", 64'(bus.stallreq_ms), 64'(0));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_idle_fwd", 64'(bus.ms_to_es_bus), 64'({1'b1, 5'd13, 32'h99}));
        applyStimulus('0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized stream");
        cur_valid   = 1'b0;
        cur_is_load = 1'b0;
        resp_active = 1'b0;
        resp_lat    = 0;
        resp_word   = 32'h0;
        pc_ctr      = 32'h8000;
        issued      = 0;
        cycles      = 0;
        while ((issued < NUM_RAND || cur_valid || exp_q.size() != 0 || resp_active) && cycles < MAX_CYCLES) begin
            @(negedge clk);
            if (resp_active && resp_lat == 0) begin
                bus.data_sram_data_ok = 1'b1;
                bus.data_sram_rdata   = resp_word;
                resp_active           = 1'b0;
            end else begin
                bus.data_sram_data_ok = 1'b0;
                bus.data_sram_rdata   = $urandom;
                if (resp_active) resp_lat--;
            end
            wb_stall = ($urandom_range(0, 3) == 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            if (!cur_valid && issued < NUM_RAND) begin
                gen_inst();
                issued++;
            end
            present = cur_valid && ($urandom_range(0, 5) != 0);
            bus.es_to_ms_bus = present ? cur_inst : '0;
            #1;
            checkOutput("rand_stallreq", 64'(bus.stallreq_ms), 64'(resp_active));
            if (!wb_stall && bus.ms_to_ws_bus[101]) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_extra_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rand_dest", 64'(bus.ms_to_ws_bus[100:96]), 64'(e.dest));
                    checkOutput("rand_value", 64'(bus.ms_to_ws_bus[95:64]), 64'(e.value));
                    checkOutput("rand_pc", 64'(bus.ms_to_ws_bus[63:32]), 64'(e.pc));
                    checkOutput("rand_fwd", 64'(bus.ms_to_es_bus), 64'({1'b1, e.dest, e.value}));
                end
            end
            if (present && !bus.stall[3]) begin
                cur_valid = 1'b0;
                if (cur_we) exp_q.push_back('{cur_dest, cur_value, cur_pc});
                if (cur_is_load) begin
                    resp_active = 1'b1;
                    resp_lat    = cur_lat;
                    resp_word   = cur_word;
                end
            end
            cycles++;
        end
        checkOutput("rand_timeout", 64'(cycles >= MAX_CYCLES), 64'(0));
        checkOutput("rand_drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
